// File: rtl/imem_pkg.sv
// ============================================================================
//  Module  : imem_pkg
//  Purpose : Shared types, constants and the address range check used by the
//            instruction memory server (load path and fetch path).
//  Contents: imem_state_e  - LOAD / RUN operating states
//            IMEM_NOP      - default filler word (addi x0,x0,0)
//            imem_in_range - aligned, >= base, index < depth
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package imem_pkg;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } imem_state_e;

    localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

    // The below-base case is caught by an explicit compare so that a wrapped
    // subtraction can never alias into a valid index.
    function automatic logic imem_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] depth);
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] == 2'b00) && (addr >= base) && ((off >> 2) < depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_server_if.sv
// ============================================================================
//  Module  : imem_server_if
//  Purpose : Fetch port and program-load port of the instruction server.
//  Signals : pc_i/inst_o          - core fetch address / returned word
//            ld_valid_i/ld_ready_o - load beat handshake
//            ld_addr_i/ld_data_i   - load beat byte address / word
//            ld_done_i             - loader finished
//            run_o, ld_count_o, ld_err_o, fetch_fault_o - status
//  Modports: slave  - the server
//            master - the bench / SoC shell driving loads and fetches
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface imem_server_if #(
    parameter int DEPTH_WORDS = 1024
);
    localparam int CW = $clog2(DEPTH_WORDS + 1);

    logic [31:0]   pc_i;
    logic [31:0]   inst_o;
    logic          ld_valid_i;
    logic          ld_ready_o;
    logic [31:0]   ld_addr_i;
    logic [31:0]   ld_data_i;
    logic          ld_done_i;
    logic          run_o;
    logic [CW-1:0] ld_count_o;
    logic          ld_err_o;
    logic          fetch_fault_o;

    modport slave (
        input  pc_i, ld_valid_i, ld_addr_i, ld_data_i, ld_done_i,
        output inst_o, ld_ready_o, run_o, ld_count_o, ld_err_o, fetch_fault_o
    );

    modport master (
        output pc_i, ld_valid_i, ld_addr_i, ld_data_i, ld_done_i,
        input  inst_o, ld_ready_o, run_o, ld_count_o, ld_err_o, fetch_fault_o
    );

endinterface

`default_nettype wire

// File: rtl/imem_array.sv
// ============================================================================
//  Module  : imem_array
//  Purpose : Instruction word storage, one write port and one registered
//            read port. No reset: contents survive a reset of the server.
//  Ports   : clk                 - clock
//            i_we/i_waddr/i_wdata - write port
//            i_re/i_raddr         - read request, data on o_rdata next cycle
//            o_rdata              - registered read data
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_waddr,
    input  wire logic [31:0]   i_wdata,
    input  wire logic          i_re,
    input  wire logic [AW-1:0] i_raddr,
    output logic [31:0]        o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_server.sv
// ============================================================================
//  Module  : imem_server
//  Purpose : Instruction-side responder. Accepts a program image through the
//            load port while in LOAD, then in RUN answers each pc with the
//            addressed word one clock later.
//  Ports   : clk         - clock, rising edge
//            rst         - asynchronous reset, active low
//            bus         - imem_server_if.slave (fetch + load + status)
//            fetch_cnt_o - RUN fetch edge counter (only with the option)
//  Option  : IMEM_FETCH_CNT_EN adds fetch_cnt_o [31:0].
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_server
    import imem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD    = IMEM_NOP
) (
    input  wire logic    clk,
    input  wire logic    rst,
    imem_server_if.slave bus
`ifdef IMEM_FETCH_CNT_EN
    ,
    output logic [31:0]  fetch_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(DEPTH_WORDS + 1);

    imem_state_e   r_state;
    imem_state_e   w_state_nxt;
    logic          w_ld_ready;
    logic          w_run;

    logic          r_use_arr;   // last RUN fetch was in range
    logic [CW-1:0] r_ld_count;
    logic          r_ld_err;
    logic          r_fault;
    logic [31:0]   w_rdata;

    logic          w_ld_fire;
    logic          w_ld_ok;
    logic          w_pc_ok;
    logic [AW-1:0] w_ld_idx;
    logic [AW-1:0] w_pc_idx;

    assign w_ld_fire = bus.ld_valid_i && w_ld_ready;
    assign w_ld_ok   = imem_in_range(bus.ld_addr_i, BASE_ADDR, 32'(DEPTH_WORDS));
    assign w_pc_ok   = imem_in_range(bus.pc_i, BASE_ADDR, 32'(DEPTH_WORDS));
    // Only the low index bits reach the array; they matter only once the
    // range check has passed.
    assign w_ld_idx  = AW'((bus.ld_addr_i - BASE_ADDR) >> 2);
    assign w_pc_idx  = AW'((bus.pc_i - BASE_ADDR) >> 2);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next state / outputs ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_ld_ready  = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            LOAD: begin
                w_ld_ready = 1'b1;
                if (bus.ld_done_i) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    // ---------------- load bookkeeping and fetch status ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ld_count <= '0;
            r_ld_err   <= 1'b0;
            r_fault    <= 1'b0;
            r_use_arr  <= 1'b0;
        end else begin
            if (w_ld_fire) begin
                if (w_ld_ok) begin
                    if (r_ld_count != '1) begin
                        r_ld_count <= r_ld_count + CW'(1);
                    end
                end else begin
                    r_ld_err <= 1'b1;
                end
            end
            if (w_run) begin
                r_use_arr <= w_pc_ok;
                if (!w_pc_ok) begin
                    r_fault <= 1'b1;
                end
            end else begin
                r_use_arr <= 1'b0;
            end
        end
    end

`ifdef IMEM_FETCH_CNT_EN
    logic [31:0] r_fetch_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_cnt <= '0;
        end else if (w_run) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
`endif

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_ld_fire && w_ld_ok),
        .i_waddr (w_ld_idx),
        .i_wdata (bus.ld_data_i),
        .i_re    (w_run && w_pc_ok),
        .i_raddr (w_pc_idx),
        .o_rdata (w_rdata)
    );

    // The array has no reset, so the registered select keeps inst_o at the
    // filler word through reset and for faulting fetches.
    assign bus.inst_o        = r_use_arr ? w_rdata : NOP_WORD;
    assign bus.ld_ready_o    = w_ld_ready;
    assign bus.run_o         = w_run;
    assign bus.ld_count_o    = r_ld_count;
    assign bus.ld_err_o      = r_ld_err;
    assign bus.fetch_fault_o = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_imem_server.sv
// ============================================================================
//  Module  : tb_imem_server
//  Purpose : Self-checking bench for imem_server (DEPTH_WORDS=1024, base 0).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_server;
    import imem_pkg::*;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    imem_server_if #(.DEPTH_WORDS(DEPTH)) bus ();

`ifdef IMEM_FETCH_CNT_EN
    logic [31:0] fetch_cnt;
`endif

    imem_server #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (32'h0000_0000),
        .NOP_WORD    (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef IMEM_FETCH_CNT_EN
        ,
        .fetch_cnt_o (fetch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
        logic [31:0] pc;
        logic [31:0] e_inst;
        logic        e_rdy;
        logic        e_run;
        logic [10:0] e_cnt;
        logic        e_err;
        logic        e_flt;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] inst, input logic rdy,
                           input logic run, input logic [10:0] cnt, input logic err,
                           input logic flt);
        chk({tag, ".inst"},  bus.inst_o, inst);
        chk({tag, ".ready"}, 32'(bus.ld_ready_o), 32'(rdy));
        chk({tag, ".run"},   32'(bus.run_o), 32'(run));
        chk({tag, ".count"}, 32'(bus.ld_count_o), 32'(cnt));
        chk({tag, ".err"},   32'(bus.ld_err_o), 32'(err));
        chk({tag, ".fault"}, 32'(bus.fetch_fault_o), 32'(flt));
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic dn, input logic [31:0] p);
        bus.ld_valid_i = v;
        bus.ld_addr_i  = a;
        bus.ld_data_i  = d;
        bus.ld_done_i  = dn;
        bus.pc_i       = p;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;

        //          vld  addr          data          done pc            inst          rdy  run  cnt  err  flt
        vecs[0]  = '{1'b1, 32'h0,        32'h00500093, 1'b0, 32'h0,        NOP,          1'b1,1'b0,11'd1,1'b0,1'b0};
        vecs[1]  = '{1'b1, 32'h4,        32'h00a00113, 1'b0, 32'h0,        NOP,          1'b1,1'b0,11'd2,1'b0,1'b0};
        vecs[2]  = '{1'b1, 32'h8,        32'h002081b3, 1'b0, 32'h0,        NOP,          1'b1,1'b0,11'd3,1'b0,1'b0};
        vecs[3]  = '{1'b1, 32'hC,        32'h00000013, 1'b0, 32'h4,        NOP,          1'b1,1'b0,11'd4,1'b0,1'b0};
        vecs[4]  = '{1'b1, 32'h6,        32'hAAAAAAAA, 1'b0, 32'h0,        NOP,          1'b1,1'b0,11'd4,1'b1,1'b0};
        vecs[5]  = '{1'b1, 32'h1000,     32'hBBBBBBBB, 1'b0, 32'h0,        NOP,          1'b1,1'b0,11'd4,1'b1,1'b0};
        vecs[6]  = '{1'b1, 32'h10,       32'hDEADBEEF, 1'b1, 32'h0,        NOP,          1'b0,1'b1,11'd5,1'b1,1'b0};
        vecs[7]  = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h4,        32'h00a00113, 1'b0,1'b1,11'd5,1'b1,1'b0};
        vecs[8]  = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h8,        32'h002081b3, 1'b0,1'b1,11'd5,1'b1,1'b0};
        vecs[9]  = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h1000,     NOP,          1'b0,1'b1,11'd5,1'b1,1'b1};
        vecs[10] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        32'h00500093, 1'b0,1'b1,11'd5,1'b1,1'b1};
        vecs[11] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h10,       32'hDEADBEEF, 1'b0,1'b1,11'd5,1'b1,1'b1};
        vecs[12] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'hFFFFFFFC, NOP,          1'b0,1'b1,11'd5,1'b1,1'b1};
        vecs[13] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h2,        NOP,          1'b0,1'b1,11'd5,1'b1,1'b1};
        vecs[14] = '{1'b1, 32'h4,        32'h11111111, 1'b1, 32'h8,        32'h002081b3, 1'b0,1'b1,11'd5,1'b1,1'b1};
        vecs[15] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h4,        32'h00a00113, 1'b0,1'b1,11'd5,1'b1,1'b1};

        // reset
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", NOP, 1'b1, 1'b0, 11'd0, 1'b0, 1'b0);
`ifdef IMEM_FETCH_CNT_EN
        chk("reset.fetch_cnt", fetch_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].vld, vecs[i].addr, vecs[i].data, vecs[i].done, vecs[i].pc);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_inst, vecs[i].e_rdy, vecs[i].e_run,
                    vecs[i].e_cnt, vecs[i].e_err, vecs[i].e_flt);
        end
`ifdef IMEM_FETCH_CNT_EN
        // vectors 7..15 are RUN fetch edges
        chk("run.fetch_cnt", fetch_cnt, 32'd9);
`endif

        // asynchronous reset mid-RUN, away from any clock edge
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", NOP, 1'b1, 1'b0, 11'd0, 1'b0, 1'b0);
`ifdef IMEM_FETCH_CNT_EN
        chk("async_rst.fetch_cnt", fetch_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // partial reload: only word 0
        drive(1'b1, 32'h0, 32'h12345678, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk_all("reload.beat", NOP, 1'b1, 1'b0, 11'd1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        @(posedge clk);
        #1;
        chk_all("reload.done", NOP, 1'b0, 1'b1, 11'd1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h4);
        @(posedge clk);
        #1;
        chk("reload.pc4", bus.inst_o, 32'h00a00113);
`ifdef IMEM_FETCH_CNT_EN
        chk("reload.fetch_cnt1", fetch_cnt, 32'd1);
`endif
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("reload.pc0", bus.inst_o, 32'h12345678);
        chk("reload.fault", 32'(bus.fetch_fault_o), 32'd0);
`ifdef IMEM_FETCH_CNT_EN
        chk("reload.fetch_cnt2", fetch_cnt, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_server.md
# imem_server

Instruction-side responder for the `riscv` core. It holds a program image written through a valid/ready load port, then answers every core `pc` with the addressed 32-bit instruction word one clock later on the core's `inst_i`. It sits in the test bench / SoC shell, opposite the core's fetch port. It replaces bench-level behavioural instruction memories.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit instruction words; a power of two, at least 2.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; 4-byte aligned.
- `NOP_WORD`, default 32'h0000_0013: word returned when no valid instruction is available (`addi x0,x0,0`).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pc_i` in 32: byte fetch address, driven by the core's `pc`.
- `inst_o` out 32: instruction word, drives the core's `inst_i`.
- `ld_valid_i` in 1: load beat valid.
- `ld_ready_o` out 1: load beat accepted when high together with `ld_valid_i`.
- `ld_addr_i` in 32: byte address of the load beat.
- `ld_data_i` in 32: instruction word to store.
- `ld_done_i` in 1: loader finished; request switch to RUN.
- `run_o` out 1: high in RUN. The bench holds the core in reset while this is low.
- `ld_count_o` out `$clog2(DEPTH_WORDS+1)`: number of accepted in-range load beats; saturates at all-ones.
- `ld_err_o` out 1: sticky flag; a handshaken load beat was misaligned or out of range.
- `fetch_fault_o` out 1: sticky flag; a RUN fetch was misaligned or out of range.

## Operation
- FSM states: LOAD and RUN. Reset enters LOAD.
- LOAD:
  - `ld_ready_o`=1 and `inst_o`=`NOP_WORD` every cycle.
  - Beat accepted when `ld_valid_i`&&`ld_ready_o`.
  - An accepted beat is in range when `ld_addr_i`[1:0]==0, `ld_addr_i`>=`BASE_ADDR`, and the index (`ld_addr_i`-`BASE_ADDR`)>>2 is less than `DEPTH_WORDS`.
  - In-range beat: write the array and increment `ld_count_o`.
  - Out-of-range beat: no write, no count change, set `ld_err_o`.
- LOAD→RUN transition:
  - Occurs at the edge where `ld_done_i`=1.
  - A beat handshaken on that same edge is still written and counted.
  - `ld_ready_o` falls to 0 with the transition.
- RUN:
  - `ld_ready_o`=0; `ld_valid_i` and `ld_done_i` are ignored.
  - Each edge samples `pc_i`. In range (same rule as loads): `inst_o` takes the array word at the computed index.
  - Out of range: `inst_o` takes `NOP_WORD` and `fetch_fault_o` is set.
  - RUN exits only through reset.
- Index arithmetic: 32-bit subtraction. `pc_i`<`BASE_ADDR` is detected by compare, not by relying on wrap-around. Only the low `$clog2(DEPTH_WORDS)` index bits address the array, after the range check passes.
- A location never written reads back as undefined (X in simulation). The array has no reset.

## Timing
- Reset values: `inst_o`=`NOP_WORD`, `ld_ready_o`=1, `run_o`=0, `ld_count_o`=0, `ld_err_o`=0, `fetch_fault_o`=0.
- Fetch latency is 1 cycle: `pc_i` sampled at edge N, word visible on `inst_o` after edge N, stable until edge N+1.
- Load write is visible to fetches from the next edge. Writes and reads never overlap, because loads only happen in LOAD.
- `run_o` rises on the edge that samples `ld_done_i`=1. The first RUN fetch is sampled on the following edge.
- Reset asserted mid-load or mid-run:
  - All flags, counters, state and `inst_o` clear immediately and asynchronously.
  - Array contents are retained.
  - A reload may overwrite any subset of words.
- Sticky flags clear only by reset.

## Configuration
- `IMEM_FETCH_CNT_EN`: when defined, adds output `fetch_cnt_o` [31:0].
  - Counts RUN fetch edges, both in range and faulting.
  - Resets to 0 and wraps modulo 2^32.
- When the macro is undefined, the port and the counter do not exist. All other behaviour is identical.

## Structure
- Shared package `imem_pkg`:
  - `imem_state_e` (LOAD, RUN).
  - `IMEM_NOP` constant (32'h0000_0013).
  - Function `imem_in_range(addr, base, depth)` returning in-range flag, shared by the load and fetch paths.
- One sub-module `imem_array`:
  - Single write port, single registered read port.
  - Parameterised by `DEPTH_WORDS`.
  - Has no reset.

## Test plan
- Reset, then load 4 beats at 0x0/0x4/0x8/0xC with data 0x00500093, 0x00a00113, 0x002081b3, 0x00000013, then `ld_done_i` → `ld_count_o`=4, `run_o`=1 next edge, `ld_ready_o`=0, `ld_err_o`=0.
- RUN, `pc_i`=0x4 at edge N → `inst_o`=0x00a00113 after edge N; `pc_i`=0x8 at N+1 → 0x002081b3.
- Load beats at 0x6 (misaligned) and at `BASE_ADDR`+4*`DEPTH_WORDS` → no write, `ld_count_o` unchanged, `ld_err_o`=1 until reset.
- RUN, `pc_i`=0x1000 with `DEPTH_WORDS`=1024 → `inst_o`=0x00000013, `fetch_fault_o`=1. Then `pc_i`=0x0 → valid word returned, `fetch_fault_o` stays 1.
- `ld_valid_i` (addr 0x10, data 0xDEADBEEF) and `ld_done_i` on the same edge → word written, `ld_count_o`+1. `pc_i`=0x10 in RUN → `inst_o`=0xDEADBEEF.
- Assert `rst` low mid-RUN → outputs at reset values without a clock edge. Reload only 0x0 with 0x12345678, then RUN, `pc_i`=0x4 → previously loaded 0x00a00113 still returned. With `IMEM_FETCH_CNT_EN`, `fetch_cnt_o` restarts from 0.
